// File: rtl/eth_frame_gen.sv
// eth_frame_gen
// Builds one complete Ethernet II frame per start request and streams it as
// bytes to the Manchester serializer. The frame is: preamble, SFD, fixed
// header, caller payload with zero pad, and CRC-32 FCS. An inter-frame gap
// follows each frame.
//
// Ports:
//   clk        system clock (40 MHz)
//   rst_n      asynchronous active-low reset
//   start      one-cycle frame request, ignored while busy
//   len        payload byte count, clamped to MAX_PAYLOAD when accepted
//   pl_data    payload byte from the caller
//   pl_valid   pl_data is valid
//   pl_ready   payload byte consumed this cycle
//   out_data   frame byte to the serializer
//   out_valid  out_data is valid (PRE through FCS)
//   out_ready  serializer takes out_data this cycle
//   out_last   current byte is the final FCS byte
//   busy       frame or inter-frame gap in progress
//   underrun   sticky, a payload byte was missing; cleared on next start
`timescale 1ns/1ps

module eth_frame_gen #(
  parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC     = 48'h0200_0000_0001,
  parameter logic [15:0] ETHERTYPE   = 16'h88B5,
  parameter int          MIN_PAYLOAD = 46,
  parameter int          MAX_PAYLOAD = 1500,
  parameter int          IFG_CYCLES  = 384
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [10:0] len,
  input  logic [7:0]  pl_data,
  input  logic        pl_valid,
  output logic        pl_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        underrun
);

  typedef enum logic [2:0] {IDLE, PRE, SFD, HDR, PAY, FCS, IFG} state_t;

  localparam logic [10:0]  MIN_LEN  = 11'(MIN_PAYLOAD);
  localparam logic [10:0]  MAX_LEN  = 11'(MAX_PAYLOAD);
  localparam logic [10:0]  IFG_LAST = 11'(IFG_CYCLES - 1);
  localparam logic [111:0] HDR_BITS = {DST_MAC, SRC_MAC, ETHERTYPE};

  state_t      state, state_next;
  logic [10:0] cnt, cnt_next;
  logic [10:0] len_q, len_next;
  logic [31:0] crc, crc_next;
  logic        underrun_next;
  logic        xfer;
  logic [10:0] pay_total;
  logic [6:0]  hdr_sel;
  logic [31:0] fcs_word;
  logic [7:0]  cur_byte;

  // Reflected CRC-32 over one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ d[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  // The source never stalls, so validity depends on state alone; this also
  // keeps xfer free of any path back through the next-state logic.
  assign out_valid = (state != IDLE) && (state != IFG);
  assign busy      = (state != IDLE);
  assign xfer      = out_valid & out_ready;
  assign out_data  = cur_byte;

  // Short payloads are padded, so the PAY phase always lasts at least MIN_LEN bytes.
  assign pay_total = (len_q < MIN_LEN) ? MIN_LEN : len_q;
  // Header byte 0 is the top byte of the 112-bit header vector.
  assign hdr_sel   = 7'd104 - {cnt[3:0], 3'b000};
  assign fcs_word  = ~crc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      len_q    <= '0;
      crc      <= 32'hFFFF_FFFF;
      underrun <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      len_q    <= len_next;
      crc      <= crc_next;
      underrun <= underrun_next;
    end
  end

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    len_next      = len_q;
    crc_next      = crc;
    underrun_next = underrun;
    cur_byte      = 8'h00;
    pl_ready      = 1'b0;
    out_last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          len_next      = (len > MAX_LEN) ? MAX_LEN : len;
          underrun_next = 1'b0;
          cnt_next      = '0;
          state_next    = PRE;
        end
      end
      PRE: begin
        cur_byte = 8'h55;
        if (xfer) begin
          if (cnt == 11'd6) begin
            cnt_next   = '0;
            state_next = SFD;
          end else begin
            cnt_next = cnt + 11'd1;
          end
        end
      end
      SFD: begin
        cur_byte = 8'hD5;
        if (xfer) begin
          crc_next   = 32'hFFFF_FFFF;
          cnt_next   = '0;
          state_next = HDR;
        end
      end
      HDR: begin
        cur_byte = HDR_BITS[hdr_sel +: 8];
        if (xfer) begin
          crc_next = crc32_byte(crc, cur_byte);
          if (cnt == 11'd13) begin
            cnt_next   = '0;
            state_next = PAY;
          end else begin
            cnt_next = cnt + 11'd1;
          end
        end
      end
      PAY: begin
        // A missing payload byte is replaced by zero and flagged, but the
        // frame keeps its length so the serializer timing is unaffected.
        if (cnt < len_q) begin
          pl_ready = out_ready;
          cur_byte = pl_valid ? pl_data : 8'h00;
          if (xfer && !pl_valid) underrun_next = 1'b1;
        end
        if (xfer) begin
          crc_next = crc32_byte(crc, cur_byte);
          if (cnt == pay_total - 11'd1) begin
            cnt_next   = '0;
            state_next = FCS;
          end else begin
            cnt_next = cnt + 11'd1;
          end
        end
      end
      FCS: begin
        cur_byte = fcs_word[{cnt[1:0], 3'b000} +: 8];
        out_last = (cnt == 11'd3);
        if (xfer) begin
          if (cnt == 11'd3) begin
            cnt_next   = '0;
            state_next = IFG;
          end else begin
            cnt_next = cnt + 11'd1;
          end
        end
      end
      IFG: begin
        if (cnt == IFG_LAST) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt + 11'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_eth_frame_gen.sv
// tb_eth_frame_gen
// Self-checking bench for eth_frame_gen. Each frame request pushes its
// expected byte sequence into a queue; an independent monitor pops and
// compares on every out_valid & out_ready, and checks the CRC residue of
// each completed frame.
`timescale 1ns/1ps

module tb_eth_frame_gen;

  logic        clk, rst_n, start;
  logic [10:0] len;
  logic [7:0]  pl_data;
  logic        pl_valid, pl_ready;
  logic [7:0]  out_data;
  logic        out_valid, out_ready, out_last, busy, underrun;

  typedef struct {
    logic [7:0] data;
    bit         chk;
    bit         crc_init;
    bit         crc_en;
    bit         last;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fails  = 0;
  int          busy_cnt = 0;
  int          preq_cnt = 0;
  int          byte_no  = 0;
  int          pay_idx  = 0;
  int          drop_idx = -1;
  bit          slow_mode = 1'b0;
  logic [31:0] crc_tb = 32'hFFFF_FFFF;
  logic [7:0]  hdr_tb [14] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                               8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
                               8'h88, 8'hB5};

  eth_frame_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .pl_data   (pl_data),
    .pl_valid  (pl_valid),
    .pl_ready  (pl_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .underrun  (underrun)
  );

  // 40 MHz clock.
  initial begin
    clk = 1'b0;
    forever #12.5 clk = ~clk;
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Byte-at-a-time reflected CRC-32: fold the byte in, then shift 8 times.
  function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in ^ {24'h0, d};
    for (int b = 0; b < 8; b++) begin
      c = c[0] ? ({1'b0, c[31:1]} ^ 32'hEDB88320) : {1'b0, c[31:1]};
    end
    return c;
  endfunction

  function automatic exp_t mk(input logic [7:0] d, input bit chk, input bit init, input bit en, input bit last);
    exp_t e;
    e.data = d; e.chk = chk; e.crc_init = init; e.crc_en = en; e.last = last;
    return e;
  endfunction

  // Serializer model: always ready, or ready one cycle in eight.
  initial begin
    int cyc;
    cyc = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      out_ready = slow_mode ? ((cyc % 8) == 0) : 1'b1;
    end
  end

  // Payload source: presents byte value = payload index, advancing after each
  // consumed byte; pl_valid is dropped on the chosen index.
  initial begin
    bit took, restart;
    pl_data  = 8'h00;
    pl_valid = 1'b0;
    forever begin
      @(negedge clk);
      took    = pl_ready;
      restart = start && !busy;
      @(posedge clk);
      #1;
      if (restart) pay_idx = 0;
      else if (took) pay_idx++;
      pl_data  = 8'(pay_idx);
      pl_valid = (pay_idx != drop_idx);
    end
  end

  // Monitor: pops one expected entry per transfer and tracks the residue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (start && !busy && rst_n) begin
        busy_cnt = 0;
        preq_cnt = 0;
        byte_no  = 0;
      end
      if (busy) busy_cnt++;
      if (pl_ready) preq_cnt++;
      if (out_valid && out_ready) begin
        byte_no++;
        if (exp_q.size() == 0) begin
          check_output($sformatf("unexpected byte %0d", byte_no), {24'h0, out_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          if (e.crc_init) crc_tb = 32'hFFFF_FFFF;
          if (e.chk) check_output($sformatf("data byte %0d", byte_no), {24'h0, out_data}, {24'h0, e.data});
          check_output($sformatf("out_last byte %0d", byte_no), {31'h0, out_last}, {31'h0, e.last});
          if (e.crc_en) crc_tb = crc_step(crc_tb, out_data);
          if (e.last) check_output("fcs residue", crc_tb, 32'hDEBB20E3);
        end
      end
    end
  end

  // Queue a frame's expected bytes (only the first 'cut' if nonzero), then
  // pulse start and confirm the first byte appears the next cycle.
  task automatic apply_stimulus(input int len_in, input int drop, input bit slow, input int cut);
    exp_t frame[$];
    int   len_c, pay_n;
    len_c = (len_in > 1500) ? 1500 : len_in;
    pay_n = (len_c < 46) ? 46 : len_c;
    for (int i = 0; i < 7; i++) frame.push_back(mk(8'h55, 1'b1, 1'b0, 1'b0, 1'b0));
    frame.push_back(mk(8'hD5, 1'b1, 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < 14; i++) frame.push_back(mk(hdr_tb[i], 1'b1, 1'b0, 1'b1, 1'b0));
    for (int i = 0; i < pay_n; i++)
      frame.push_back(mk((i < len_c && i != drop) ? 8'(i) : 8'h00, 1'b1, 1'b0, 1'b1, 1'b0));
    for (int i = 0; i < 4; i++) frame.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, i == 3));
    for (int i = 0; i < frame.size(); i++)
      if (cut == 0 || i < cut) exp_q.push_back(frame[i]);
    drop_idx  = drop;
    slow_mode = slow;
    len       = 11'(len_in);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check_output("out_valid one cycle after start", {31'h0, out_valid}, 32'h1);
  endtask

  task automatic wait_frame(input int bound);
    bit done;
    done = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check_output("frame completion timeout", 32'(exp_q.size()), 32'h0);
  endtask

  task automatic wait_idle(input int bound);
    bit done;
    done = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check_output("busy release timeout", {31'h0, busy}, 32'h0);
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    len   = 11'd0;
    repeat (2) @(negedge clk);
    check_output("reset out_valid", {31'h0, out_valid}, 32'h0);
    check_output("reset out_last", {31'h0, out_last}, 32'h0);
    check_output("reset pl_ready", {31'h0, pl_ready}, 32'h0);
    check_output("reset busy", {31'h0, busy}, 32'h0);
    check_output("reset underrun", {31'h0, underrun}, 32'h0);
    check_output("reset out_data", {24'h0, out_data}, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    $display("[TB] len=0 minimum frame");
    apply_stimulus(0, -1, 1'b0, 0);
    wait_frame(200);
    wait_idle(1000);
    check_output("len0 busy cycles", 32'(busy_cnt), 32'd456);
    check_output("len0 underrun", {31'h0, underrun}, 32'h0);
    check_output("len0 pl_ready pulses", 32'(preq_cnt), 32'd0);

    $display("[TB] len=60 with slow serializer");
    apply_stimulus(60, -1, 1'b1, 0);
    wait_frame(2000);
    wait_idle(1000);
    check_output("len60 pl_ready pulses", 32'(preq_cnt), 32'd60);
    check_output("len60 underrun", {31'h0, underrun}, 32'h0);

    $display("[TB] len=10 with missing payload byte 4");
    apply_stimulus(10, 4, 1'b0, 0);
    wait_frame(200);
    check_output("underrun set after frame", {31'h0, underrun}, 32'h1);
    wait_idle(1000);
    check_output("underrun held in idle", {31'h0, underrun}, 32'h1);
    check_output("len10 pl_ready pulses", 32'(preq_cnt), 32'd10);

    $display("[TB] len=2047 clamped to 1500");
    apply_stimulus(2047, -1, 1'b0, 0);
    check_output("underrun cleared by start", {31'h0, underrun}, 32'h0);
    wait_frame(2000);
    wait_idle(1000);
    check_output("len2047 pl_ready pulses", 32'(preq_cnt), 32'd1500);

    $display("[TB] starts during PAY and IFG are ignored");
    apply_stimulus(0, -1, 1'b0, 0);
    repeat (40) @(posedge clk);
    #1 start = 1'b1;
    len = 11'd20;
    @(posedge clk);
    #1 start = 1'b0;
    wait_frame(200);
    repeat (100) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle(1000);
    check_output("busy cycles with ignored starts", 32'(busy_cnt), 32'd456);
    apply_stimulus(3, -1, 1'b0, 0);
    wait_frame(200);
    wait_idle(1000);

    $display("[TB] reset during header");
    apply_stimulus(0, -1, 1'b0, 13);
    wait_frame(100);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_output("mid-frame reset out_valid", {31'h0, out_valid}, 32'h0);
    check_output("mid-frame reset busy", {31'h0, busy}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_output("post-reset out_valid", {31'h0, out_valid}, 32'h0);
    check_output("post-reset busy", {31'h0, busy}, 32'h0);
    apply_stimulus(5, -1, 1'b0, 0);
    wait_frame(200);
    wait_idle(1000);
    check_output("post-reset frame underrun", {31'h0, underrun}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/eth_frame_gen.md
Name: eth_frame_gen

Overview:
- Upstream byte-stream source for the Manchester 10BASE-T transmitter.
- On a start pulse it emits one complete Ethernet II frame as bytes over a valid/ready interface: preamble, SFD, fixed header, caller payload with zero pad, and CRC-32 FCS.
- After the frame it enforces an inter-frame gap.
- The serializer downstream pulls one byte per 8 bit-times.

Parameters:
- DST_MAC, 48'hFFFF_FFFF_FFFF, destination MAC, sent MSB byte first.
- SRC_MAC, 48'h0200_0000_0001, source MAC, sent MSB byte first.
- ETHERTYPE, 16'h88B5, EtherType, sent MSB byte first.
- MIN_PAYLOAD, 46, minimum payload length; shorter payloads are zero-padded up to this.
- MAX_PAYLOAD, 1500, upper clamp on the len input.
- IFG_CYCLES, 384, idle clk cycles after the last FCS byte; 96 bit-times at 40 MHz.

Ports:
- clk  in  1  system clock (40 MHz PLL output)
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle frame request; ignored while busy=1
- len  in  11  payload byte count, sampled when start is accepted; values above MAX_PAYLOAD are clamped
- pl_data  in  8  payload byte
- pl_valid  in  1  pl_data valid
- pl_ready  out  1  payload byte consumed this cycle
- out_data  out  8  frame byte to the serializer
- out_valid  out  1  out_data valid
- out_ready  in  1  serializer takes out_data this cycle
- out_last  out  1  current byte is the final FCS byte
- busy  out  1  frame or IFG in progress
- underrun  out  1  sticky: payload byte missing during frame; cleared on the next accepted start

Behaviour:
- Reset is async on rst_n low. State goes to IDLE and all counters to 0. Outputs reset to: out_valid=0, out_last=0, pl_ready=0, busy=0, underrun=0, out_data=8'h00. CRC register resets to 32'hFFFF_FFFF. A reset mid-frame abandons the frame; nothing resumes after release.
- Byte transfer occurs only when out_valid & out_ready. Counters and CRC advance only on a transfer. out_valid is 1 in every state from PRE through FCS; the source never stalls.
- States:
  - IDLE: out_valid=0. When start=1, latch len_q=min(len,MAX_PAYLOAD), clear underrun, set busy, go to PRE. Cycle N start gives cycle N+1 out_valid=1 with out_data=8'h55.
  - PRE: 7 bytes of 8'h55, then SFD.
  - SFD: 1 byte of 8'hD5, then HDR. CRC is re-initialised to 32'hFFFF_FFFF on the SFD transfer.
  - HDR: 14 bytes, DST_MAC[47:40] first through ETHERTYPE[7:0]. CRC updates on each byte.
  - PAY: payload bytes from index 0 to len_q-1, then pad bytes up to index MIN_PAYLOAD-1; pad bytes are 8'h00. If len_q=0, the frame carries MIN_PAYLOAD pad bytes. CRC updates on each byte. Total PAY bytes = max(len_q, MIN_PAYLOAD).
    - In the data phase (index < len_q): pl_ready = out_ready; out_data = pl_valid ? pl_data : 8'h00.
    - A transfer with pl_valid=0 sets underrun; the index still advances.
    - pl_ready is 0 in every other state and during padding.
  - FCS: 4 bytes of ~crc, least-significant byte first. out_last=1 on the 4th byte. After that transfer, go to IFG.
  - IFG: out_valid=0, busy=1. Count IFG_CYCLES clk cycles, then go to IDLE with busy=0. A start during IFG is ignored.
- CRC-32: IEEE reflected polynomial 32'hEDB88320, bytes processed LSB first, one byte per transfer. The update is combinational over 8 bit-steps, registered.
- Frame length on the wire = 8 + 14 + max(len_q,46) + 4 bytes. At len_q=1500 this is 1526 bytes.
- The payload index is 11 bits and must not wrap at the 1500 clamp. len=2047 gives 1500 bytes.
- If start and rst_n deassertion fall in the same cycle, reset wins.

Test Plan:
- Reset, then start with len=0, out_ready held 1 -> 72 bytes: 55×7, D5, FF FF FF FF FF FF 02 00 00 00 00 01 88 B5, 46×00, 4-byte FCS. out_last only on byte 72; busy=1 for 72+384 cycles after start; underrun=0.
- len=60, pl_data=index, pl_valid=1, out_ready toggled 1-of-8 cycles -> 86 bytes. Payload bytes are 00..3B with no pad. The bench CRC model over bytes 9..86 gives residue 32'hDEBB20E3. pl_ready pulses exactly 60 times.
- len=10 with pl_valid dropped on payload index 4 -> byte 27 is 8'h00 and underrun=1 until the next start. Frame still 72 bytes with a correct FCS over the bytes as sent.
- len=2047 -> exactly 1500 payload bytes, total 1526. The FCS residue check passes.
- Start pulses during PAY and during IFG -> ignored, no second frame. A start one cycle after the IFG ends -> new frame begins the following cycle.
- rst_n low during HDR byte 5 -> next cycle out_valid=0, busy=0. After release, no output until a new start, whose frame is full and correct.
